// File: rtl/adc_sample_formatter.sv
// Formats NCH ADC codes to odd-symmetric signed samples and counts full-scale hits per AGC window.
// 1-cycle latency, in_valid-qualified with no backpressure; out_valid is in_valid delayed by one clock.
module adc_sample_formatter #(
  parameter int NCH      = 1,
  parameter int IN_W     = 2,
  parameter int WIN_LOG2 = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  mode,
  input  logic                        in_valid,
  input  logic [NCH*IN_W-1:0]         adc_in,
  input  logic                        agc_clr,
  output logic                        out_valid,
  output logic [NCH*(IN_W+1)-1:0]     sample_out,
  output logic [NCH*(WIN_LOG2+1)-1:0] mag_cnt,
  output logic                        mag_cnt_valid
);

  localparam int OW = IN_W + 1;
  localparam int CW = WIN_LOG2 + 1;
  // Full-scale sample values +F and -F, with F = 2**IN_W - 1 (and -F = 2**IN_W + 1 mod 2**OW).
  localparam logic [OW-1:0] FS_POS = OW'((1 << IN_W) - 1);
  localparam logic [OW-1:0] FS_NEG = OW'((1 << IN_W) + 1);

  function automatic logic [OW-1:0] fmt_code(input logic [IN_W-1:0] code, input logic [1:0] md);
    logic [OW-1:0] mag;
    mag = {1'b0, code[IN_W-2:0], 1'b1};
    case (md)
      2'b01:   fmt_code = code[IN_W-1] ? (~mag + OW'(1)) : mag;
      2'b10:   fmt_code = {code, 1'b0} - FS_POS;
      default: fmt_code = {code, 1'b1};
    endcase
  endfunction

  logic [OW-1:0]       conv [NCH];
  logic [NCH-1:0]      fs;
  logic [CW-1:0]       acc  [NCH];
  logic [WIN_LOG2-1:0] win_cnt;
  logic                stats_en;
  logic                terminal;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      conv[c] = fmt_code(adc_in[c*IN_W +: IN_W], mode);
      fs[c]   = (conv[c] == FS_POS) || (conv[c] == FS_NEG);
    end
  end

  // A cleared cycle still formats its sample but never contributes to, or closes, a window.
  assign stats_en = in_valid & ~agc_clr;
  assign terminal = stats_en & (&win_cnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      sample_out    <= '0;
      mag_cnt       <= '0;
      mag_cnt_valid <= 1'b0;
      win_cnt       <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      out_valid     <= in_valid;
      mag_cnt_valid <= terminal;
      if (in_valid) begin
        for (int c = 0; c < NCH; c++) sample_out[c*OW +: OW] <= conv[c];
      end
      if (agc_clr) begin
        win_cnt <= '0;
        for (int c = 0; c < NCH; c++) acc[c] <= '0;
      end else if (stats_en) begin
        win_cnt <= terminal ? '0 : win_cnt + WIN_LOG2'(1);
        for (int c = 0; c < NCH; c++) begin
          if (terminal) begin
            mag_cnt[c*CW +: CW] <= acc[c] + CW'(fs[c]);
            acc[c]              <= '0;
          end else begin
            acc[c] <= acc[c] + CW'(fs[c]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_formatter.sv
// Directed bench for adc_sample_formatter with NCH=2, IN_W=2, WIN_LOG2=3 (8-sample AGC window).
module tb_adc_sample_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic [3:0] adc_in = '0;
  logic       agc_clr = 1'b0;
  logic       out_valid;
  logic [5:0] sample_out;
  logic [7:0] mag_cnt;
  logic       mag_cnt_valid;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_mag = 8'h00;

  adc_sample_formatter #(.NCH(2), .IN_W(2), .WIN_LOG2(3)) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .in_valid(in_valid),
    .adc_in(adc_in),
    .agc_clr(agc_clr),
    .out_valid(out_valid),
    .sample_out(sample_out),
    .mag_cnt(mag_cnt),
    .mag_cnt_valid(mag_cnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, then check every output one step after the edge.
  task automatic cyc(input string tag, input logic v, input logic clr,
                     input logic [1:0] c0, input logic [1:0] c1,
                     input logic [2:0] e0, input logic [2:0] e1, input logic ep);
    in_valid = v;
    agc_clr  = clr;
    adc_in   = {c1, c0};
    @(posedge clk);
    #1;
    chk({tag, "_ov"}, 32'(out_valid), 32'(v));
    chk({tag, "_so"}, 32'(sample_out), 32'({e1, e0}));
    chk({tag, "_mv"}, 32'(mag_cnt_valid), 32'(ep));
    chk({tag, "_mc"}, 32'(mag_cnt), 32'(exp_mag));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_so", 32'(sample_out), 32'd0);
    chk("rst_mc", 32'(mag_cnt), 32'd0);
    chk("rst_mv", 32'(mag_cnt_valid), 32'd0);
    reset = 1'b1;

    // Two's-odd legacy mapping; ch1 runs the codes in reverse.
    mode = 2'b00;
    cyc("m00_a", 1, 0, 2'b00, 2'b11, 3'b001, 3'b111, 0);
    cyc("m00_b", 1, 0, 2'b01, 2'b10, 3'b011, 3'b101, 0);
    cyc("m00_c", 1, 0, 2'b10, 2'b01, 3'b101, 3'b011, 0);
    cyc("m00_d", 1, 0, 2'b11, 2'b00, 3'b111, 3'b001, 0);
    // Sign-magnitude; the 8th valid sample since reset closes the first window (4 hits each).
    mode = 2'b01;
    cyc("m01_a", 1, 0, 2'b00, 2'b11, 3'b001, 3'b101, 0);
    cyc("m01_b", 1, 0, 2'b01, 2'b10, 3'b011, 3'b111, 0);
    cyc("m01_c", 1, 0, 2'b10, 2'b01, 3'b111, 3'b011, 0);
    exp_mag = 8'h44;
    cyc("m01_d", 1, 0, 2'b11, 2'b00, 3'b101, 3'b001, 1);
    // Offset-binary.
    mode = 2'b10;
    cyc("m10_a", 1, 0, 2'b00, 2'b11, 3'b101, 3'b011, 0);
    cyc("m10_b", 1, 0, 2'b01, 2'b10, 3'b111, 3'b001, 0);
    cyc("m10_c", 1, 0, 2'b10, 2'b01, 3'b001, 3'b111, 0);
    cyc("m10_d", 1, 0, 2'b11, 2'b00, 3'b011, 3'b101, 0);
    // Reserved mode behaves as two's-odd.
    mode = 2'b11;
    cyc("m11_a", 1, 0, 2'b10, 2'b01, 3'b101, 3'b011, 0);
    cyc("clr_a", 0, 1, 2'b11, 2'b11, 3'b101, 3'b011, 0);

    // Window with gaps: ch0 full-scale on samples 2,5,8; ch1 on all 8.
    mode = 2'b00;
    cyc("win_1", 1, 0, 2'b00, 2'b01, 3'b001, 3'b011, 0);
    cyc("win_2", 1, 0, 2'b01, 2'b10, 3'b011, 3'b101, 0);
    cyc("win_3", 1, 0, 2'b11, 2'b01, 3'b111, 3'b011, 0);
    cyc("gap_a", 0, 0, 2'b01, 2'b00, 3'b111, 3'b011, 0);
    cyc("gap_b", 0, 0, 2'b10, 2'b11, 3'b111, 3'b011, 0);
    cyc("win_4", 1, 0, 2'b00, 2'b10, 3'b001, 3'b101, 0);
    cyc("win_5", 1, 0, 2'b10, 2'b01, 3'b101, 3'b011, 0);
    cyc("win_6", 1, 0, 2'b11, 2'b10, 3'b111, 3'b101, 0);
    cyc("gap_c", 0, 0, 2'b00, 2'b00, 3'b111, 3'b101, 0);
    cyc("win_7", 1, 0, 2'b00, 2'b01, 3'b001, 3'b011, 0);
    exp_mag = 8'h83;
    cyc("win_8", 1, 0, 2'b01, 2'b10, 3'b011, 3'b101, 1);
    cyc("gap_d", 0, 0, 2'b11, 2'b11, 3'b011, 3'b101, 0);

    // Following window starts from zero: ch0 full-scale throughout, ch1 never.
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_mag = 8'h08;
      cyc($sformatf("nxt_%0d", i), 1, 0, 2'b10, 2'b00, 3'b101, 3'b001, i == 8);
    end

    // agc_clr on the 5th valid sample restarts counting; only the 8 after it count.
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("pre_%0d", i), 1, 0, 2'b01, 2'b10, 3'b011, 3'b101, 0);
    cyc("clr_5", 1, 1, 2'b10, 2'b01, 3'b101, 3'b011, 0);
    for (int i = 1; i <= 8; i++) begin
      logic [1:0] c0, c1;
      c0 = (i == 3 || i == 8) ? 2'b01 : 2'b00;
      c1 = (i <= 5) ? 2'b10 : 2'b11;
      if (i == 8) exp_mag = 8'h52;
      cyc($sformatf("post_%0d", i), 1, 0, c0, c1, {c0, 1'b1}, {c1, 1'b1}, i == 8);
    end

    // agc_clr coincident with a terminal sample suppresses the pulse.
    for (int i = 1; i <= 7; i++)
      cyc($sformatf("tc_%0d", i), 1, 0, 2'b00, 2'b11, 3'b001, 3'b111, 0);
    cyc("tc_clr", 1, 1, 2'b01, 2'b10, 3'b011, 3'b101, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_mag = 8'h08;
      cyc($sformatf("aft_%0d", i), 1, 0, 2'b01, 2'b00, 3'b011, 3'b001, i == 8);
    end

    // Asynchronous reset mid-window clears outputs before the next edge.
    mode = 2'b10;
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("pr_%0d", i), 1, 0, 2'b01, 2'b11, 3'b111, 3'b011, 0);
    reset = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_so", 32'(sample_out), 32'd0);
    chk("arst_mc", 32'(mag_cnt), 32'd0);
    chk("arst_mv", 32'(mag_cnt_valid), 32'd0);
    exp_mag = 8'h00;
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) exp_mag = 8'h80;
      cyc($sformatf("rr_%0d", i), 1, 0, 2'b01, 2'b11, 3'b111, 3'b011, i == 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
